frame_tx_serializer: RTL and testbench
======================================

FRAME_TX_SERIALIZER -- requirements
Module: frame_tx_serializer

Interface
REQ-001 Parameter NUM_BYTES, default 220: number of bytes per frame.
REQ-002 Parameter DATA_BITS, default 8: width of one UART byte.
REQ-003 clock  input  1  single system clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sendSignal  input  1  frame-valid strobe from the upstream frame builder.
REQ-006 sendData  input  NUM_BYTES*DATA_BITS (1760)  frame payload, valid while sendSignal is high.
REQ-007 tx_full  input  1  UART TX FIFO full flag; while high, no write may be issued.
REQ-008 w_data  output  DATA_BITS  byte presented to the UART TX FIFO.
REQ-009 wr_uart  output  1  write strobe to the UART TX FIFO; one byte is accepted per cycle in which it is high.
REQ-010 busy  output  1  high while a frame is held or being sent.
REQ-011 done  output  1  one-cycle pulse after the last byte of a frame is written.

Function
REQ-012 The FSM SHALL have three states: IDLE, SEND and DONE.
REQ-013 In IDLE with sendSignal=1, the block SHALL latch all of sendData into a frame register, clear the byte counter to 0 and enter SEND on the same edge.
REQ-014 sendSignal SHALL be ignored in SEND and DONE, and no frame is queued.
REQ-015 Byte order SHALL be LSB-byte first: byte i = sendData[8i+7:8i], so sendData[7:0] is sent first and sendData[1759:1752] last.
REQ-016 w_data SHALL always equal the frame register's current byte: frame_reg[7:0], with the register shifted right by DATA_BITS after each accepted write.
REQ-017 wr_uart SHALL be combinational: (state==SEND) && !tx_full, and it SHALL be 0 in IDLE and DONE.
REQ-018 On each edge where wr_uart=1, the frame register SHALL shift and the counter SHALL increment.
REQ-019 If wr_uart=1 and counter==NUM_BYTES-1, the FSM SHALL enter DONE instead of incrementing.
REQ-020 While tx_full=1 in SEND, the counter, frame register and w_data SHALL hold, and the same byte SHALL be written once tx_full falls.
REQ-021 The byte counter SHALL be ceil(log2(NUM_BYTES)) bits wide (8 bits at the default) and SHALL never exceed NUM_BYTES-1.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE unconditionally.
REQ-023 busy SHALL equal (state != IDLE).
REQ-024 With tx_full=0 throughout, latency SHALL be: sendSignal sampled at edge k; wr_uart high in cycles k..k+219; done high in cycle k+220; IDLE from edge k+221.
REQ-025 Exactly NUM_BYTES writes SHALL occur per accepted frame: no duplicate and no dropped byte.

Reset
REQ-026 Reset asserted at any time SHALL immediately force: state=IDLE, counter=0, frame register=0, done=0, busy=0, wr_uart=0, w_data=0.
REQ-027 A frame interrupted by reset SHALL be discarded and not resumed; the next sendSignal after reset release starts a fresh frame.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/SEND/DONE) and the NUM_BYTES and DATA_BITS defaults, for reuse by the upstream frame builder.
REQ-029 The design SHALL be a single module with no sub-modules; the counter and shift register are inline.

Verification
REQ-030 Uniform frame: sendData={220{8'h42}}, tx_full=0 -> 220 consecutive wr_uart cycles with w_data=8'h42, then one done pulse, then busy=0.
REQ-031 Ordering: byte i = i (0x00..0xDB) -> w_data sequence 0x00,0x01,...,0xDB in order, with exactly 220 writes.
REQ-032 Back-pressure: tx_full=1 for 5 cycles while byte 50 is pending -> no wr_uart in those cycles, byte 0x32 written once after release, total writes = 220.
REQ-033 Overrun: sendSignal with new data (8'hFF) pulsed during SEND and during DONE -> ignored; the original frame completes unchanged and no second frame starts.
REQ-034 Reset mid-frame at byte 100 -> wr_uart=0, busy=0 and done=0 immediately; next frame of 8'h11 sends 220 bytes of 8'h11.
REQ-035 Back-to-back: sendSignal reasserted in the first IDLE cycle after done -> second frame starts, with a first write one cycle later.

Source files
------------

// File: rtl/frame_tx_serializer_pkg.sv
// Shared types and defaults for the frame serializer and the upstream frame builder.
package frame_tx_serializer_pkg;

  localparam int NUM_BYTES_DEF = 220;
  localparam int DATA_BITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/frame_tx_serializer_if.sv
// Frame-builder / UART-FIFO side signals of the serializer, bundled for binding.
// Handshake: a frame is taken when sendSignal=1 while busy=0; a byte is
// accepted by the FIFO on every rising edge where wr_uart=1, and wr_uart is
// held low whenever tx_full=1, so tx_full acts as the inverted ready.
interface frame_tx_serializer_if #(
  parameter int NUM_BYTES = frame_tx_serializer_pkg::NUM_BYTES_DEF,
  parameter int DATA_BITS = frame_tx_serializer_pkg::DATA_BITS_DEF
);

  logic                           sendSignal;
  logic [NUM_BYTES*DATA_BITS-1:0] sendData;
  logic                           tx_full;
  logic [DATA_BITS-1:0]           w_data;
  logic                           wr_uart;
  logic                           busy;
  logic                           done;

  modport master (
    output sendSignal, sendData, tx_full,
    input  w_data, wr_uart, busy, done
  );

  modport slave (
    input  sendSignal, sendData, tx_full,
    output w_data, wr_uart, busy, done
  );

endinterface

// File: rtl/frame_tx_serializer.sv
// Latches a whole frame and streams it LSB-byte first into a UART TX FIFO,
// stalling on tx_full and pulsing done after the last byte is written.
module frame_tx_serializer
  import frame_tx_serializer_pkg::*;
#(
  parameter int NUM_BYTES = NUM_BYTES_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  frame_tx_serializer_if.slave   bus,
  output tx_state_e              state_dbg
);

  localparam int FRAME_W = NUM_BYTES * DATA_BITS;
  localparam int CNT_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  tx_state_e          state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               wr;

  // A write goes out in the same cycle the FIFO has room; no extra pipeline stage.
  assign wr = (state_q == SEND) && !bus.tx_full;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.sendSignal) begin
          frame_d = bus.sendData;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (wr) begin
          frame_d = frame_q >> DATA_BITS;
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.w_data  = frame_q[DATA_BITS-1:0];
  assign bus.wr_uart = wr;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_frame_tx_serializer.sv
// Directed bench for frame_tx_serializer: uniform, ordering, back-pressure,
// overrun, mid-frame reset and back-to-back frames.
module tb_frame_tx_serializer;
  import frame_tx_serializer_pkg::*;

  localparam int NB = 220;
  localparam int DB = 8;
  localparam int FW = NB * DB;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  frame_tx_serializer_if #(.NUM_BYTES(NB), .DATA_BITS(DB)) bus ();
  tx_state_e state_dbg;

  frame_tx_serializer #(.NUM_BYTES(NB), .DATA_BITS(DB)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // scoreboard
  int              total = 0;
  int              bad   = 0;
  logic [DB-1:0]   exp_q[$];
  logic [FW-1:0]   frame_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_wr", 32'(bus.wr_uart), 0);
      chk("idle_done", 32'(bus.done), 0);
      @(posedge clock); #1;
    end
  endtask

  task automatic load_uniform(input logic [7:0] b);
    frame_v = {NB{b}};
    exp_q.delete();
    for (int i = 0; i < NB; i++) exp_q.push_back(b);
  endtask

  task automatic load_ordered();
    exp_q.delete();
    for (int i = 0; i < NB; i++) begin
      frame_v[8*i +: 8] = 8'(i);
      exp_q.push_back(8'(i));
    end
  endtask

  // driver: entered and left at posedge+1 of an IDLE cycle
  task automatic run_frame(input int stall_at, input int stall_len, input bit poke,
                           input int abort_at);
    int writes  = 0;
    int stalls  = 0;
    int dones   = 0;
    int cyc     = 0;
    bit fin     = 0;
    bit aborted = 0;
    bus.sendSignal = 1'b1;
    bus.sendData   = frame_v;
    @(negedge clock);
    chk("start_idle_busy", 32'(bus.busy), 0);
    chk("start_idle_wr", 32'(bus.wr_uart), 0);
    @(posedge clock); #1;
    bus.sendSignal = 1'b0;
    while (!fin && !aborted && cyc < NB + 50) begin
      bus.tx_full    = (writes == stall_at) && (stalls < stall_len);
      bus.sendSignal = poke && (writes == 30 || writes == NB);
      if (poke) bus.sendData = {NB{8'hFF}};
      if (writes == abort_at) begin
        reset = 1'b1;
        #1;
        chk("rst_wr", 32'(bus.wr_uart), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_wdata", 32'(bus.w_data), 0);
        chk("rst_state", 32'(state_dbg), 32'(IDLE));
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("no_resume_busy", 32'(bus.busy), 0);
        chk("no_resume_wr", 32'(bus.wr_uart), 0);
        @(posedge clock); #1;
        aborted = 1;
      end else begin
        @(negedge clock);
        if (cyc == 0) chk("first_wr_latency", 32'(bus.wr_uart), 1);
        if (bus.tx_full) begin
          stalls++;
          chk("stall_no_wr", 32'(bus.wr_uart), 0);
          chk("stall_hold_data", 32'(bus.w_data), 32'(exp_q[0]));
        end
        if (bus.wr_uart) begin
          if (exp_q.size() == 0) chk("extra_write", 1, 0);
          else chk("byte", 32'(bus.w_data), 32'(exp_q.pop_front()));
          writes++;
        end
        if (bus.done) begin
          dones++;
          chk("done_cycle", 32'(cyc), 32'(NB + stall_len));
          chk("done_no_wr", 32'(bus.wr_uart), 0);
          chk("done_busy", 32'(bus.busy), 1);
          fin = 1;
        end
        @(posedge clock); #1;
        cyc++;
      end
    end
    bus.sendSignal = 1'b0;
    bus.tx_full    = 1'b0;
    if (aborted) begin
      chk("abort_write_count", 32'(writes), 32'(abort_at));
    end else begin
      if (!fin) chk("timeout_no_done", 0, 1);
      chk("write_count", 32'(writes), 32'(NB));
      chk("queue_empty", 32'(exp_q.size()), 0);
      chk("done_pulses", 32'(dones), 1);
      chk("stall_cycles", 32'(stalls), 32'(stall_len));
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.sendSignal = 1'b0;
    bus.sendData   = '0;
    bus.tx_full    = 1'b0;
    frame_v        = '0;
    #1;
    chk("reset_wr", 32'(bus.wr_uart), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_wdata", 32'(bus.w_data), 0);
    chk("reset_state", 32'(state_dbg), 32'(IDLE));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    idle_check(2);

    // uniform frame of 0x42
    load_uniform(8'h42);
    run_frame(-1, 0, 1'b0, -1);
    idle_check(2);

    // byte i = i ordering
    load_ordered();
    run_frame(-1, 0, 1'b0, -1);
    idle_check(1);

    // back-pressure on byte 50 (0x32) for 5 cycles
    load_ordered();
    run_frame(50, 5, 1'b0, -1);
    idle_check(1);

    // overrun pulses in SEND and DONE must be ignored
    load_ordered();
    run_frame(-1, 0, 1'b1, -1);
    idle_check(4);

    // reset at byte 100, then a fresh 0x11 frame
    load_uniform(8'h42);
    run_frame(-1, 0, 1'b0, 100);
    idle_check(1);
    load_uniform(8'h11);
    run_frame(-1, 0, 1'b0, -1);

    // back-to-back: restart in the first IDLE cycle after done
    load_ordered();
    run_frame(-1, 0, 1'b0, -1);
    load_uniform(8'h11);
    run_frame(-1, 0, 1'b0, -1);
    idle_check(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
